// File: rtl/rrmux8_1_if.sv
// rtl/rrmux8_1_if.sv - valid/ready bundle for the 8:1 round-robin mux
// The master modport is the mux itself. The slave modport is the environment that offers words and consumes the output.
interface rrmux8_1_if #(
    parameter int WIDTH = 8
) ();
    logic [7:0]         in_valid;
    logic [8*WIDTH-1:0] in_data;
    logic [7:0]         in_ready;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [2:0]         out_sel;

    modport master (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/rrmux8_1.sv
// rtl/rrmux8_1.sv - 8:1 round-robin arbitrated mux with one output register stage
// Optional macro RRMUX_CNT_EN adds the 16-bit grant_cnt counter of accepted words.
module rrmux8_1 #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    rrmux8_1_if.master    bus
`ifdef RRMUX_CNT_EN
    ,
    output logic [15:0]   grant_cnt
`endif
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]       state;
    logic [2:0]       ptr;
    logic [WIDTH-1:0] data_q;
    logic [2:0]       sel_q;

    logic             load;
    logic             found;
    logic [2:0]       win;
    logic [2:0]       idx;
    logic             xfer;

    assign load = (state == EMPTY) | bus.out_ready;

    // Search upward from ptr, modulo 8; the first valid channel wins.
    always_comb begin
        found = 1'b0;
        win   = 3'd0;
        idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = ptr + 3'(i);
            if (!found && bus.in_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // rst_n gates the strobe so nothing is accepted while reset is held.
    assign xfer = rst_n & load & found;

    always_comb begin
        bus.in_ready = 8'h00;
        if (xfer) begin
            bus.in_ready = 8'h01 << win;
        end
    end

    assign bus.out_valid = (state == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            ptr    <= 3'd0;
            data_q <= '0;
            sel_q  <= 3'd0;
        end else if (xfer) begin
            state  <= FULL;
            ptr    <= win + 3'd1;
            data_q <= bus.in_data[win*WIDTH +: WIDTH];
            sel_q  <= win;
        end else if (load) begin
            state  <= EMPTY;
        end
    end

`ifdef RRMUX_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= 16'h0000;
        end else if (xfer) begin
            grant_cnt <= grant_cnt + 16'h0001;
        end
    end
`endif

endmodule
